// File: rtl/cic_decimator.sv
// N-stage IQ CIC decimator with runtime power-of-two rate (M=1).
// Integrators run at the input rate, combs at the decimated rate, and the gain is removed by a shift.
module cic_decimator #(
  parameter int IQ_NUM     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 3,
  parameter int MAX_LOG2   = 6
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                en_i,
  input  logic                                clr_i,
  input  logic [$clog2(MAX_LOG2+1)-1:0]       rate_log2_i,
  input  logic                                tvalid_i,
  input  logic [IQ_NUM-1:0][DATA_WIDTH-1:0]   tdata_i,
  output logic                                tvalid_o,
  output logic [IQ_NUM-1:0][DATA_WIDTH-1:0]   tdata_o
);

  localparam int ACC_WIDTH = DATA_WIDTH + STAGES * MAX_LOG2;
  localparam int LW        = $clog2(MAX_LOG2 + 1);
  localparam int CW        = MAX_LOG2 + 1;
  localparam int SW        = $clog2(STAGES * MAX_LOG2 + 1);

  logic [LW-1:0]   l_reg;
  logic [CW-1:0]   cnt_reg;
  logic [STAGES:0] vld_reg;   // [0]: decimated sample valid, [k]: comb k-1 output valid
  logic            tvalid_reg;
  logic            accept;
  logic            dec_last;
  logic [CW-1:0]   rate_m1;
  logic [SW-1:0]   shamt;

  assign accept   = en_i && tvalid_i && !clr_i;
  assign rate_m1  = (CW'(1) << l_reg) - CW'(1);
  assign dec_last = (cnt_reg == rate_m1);
  assign shamt    = SW'(l_reg) * SW'(STAGES);
  // A registered pulse frozen by en_i low must not be seen until enable returns.
  assign tvalid_o = tvalid_reg && en_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      l_reg      <= '0;
      cnt_reg    <= '0;
      vld_reg    <= '0;
      tvalid_reg <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        l_reg      <= (rate_log2_i > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : rate_log2_i;
        cnt_reg    <= '0;
        vld_reg    <= '0;
        tvalid_reg <= 1'b0;
      end else begin
        if (accept) begin
          cnt_reg <= dec_last ? '0 : cnt_reg + CW'(1);
        end
        vld_reg    <= {vld_reg[STAGES-1:0], accept && dec_last};
        tvalid_reg <= vld_reg[STAGES];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < IQ_NUM; gi++) begin : g_chan
      logic signed [ACC_WIDTH-1:0] integ_reg    [STAGES];
      logic signed [ACC_WIDTH-1:0] integ_next   [STAGES];
      logic signed [ACC_WIDTH-1:0] comb_reg     [STAGES];
      logic signed [ACC_WIDTH-1:0] comb_dly_reg [STAGES];
      logic signed [ACC_WIDTH-1:0] comb_in      [STAGES];
      logic signed [ACC_WIDTH-1:0] dec_reg;
      logic signed [ACC_WIDTH-1:0] x_ext;
      logic signed [ACC_WIDTH-1:0] shifted;
      logic        [DATA_WIDTH-1:0] out_reg;

      assign x_ext   = {{(ACC_WIDTH-DATA_WIDTH){tdata_i[gi][DATA_WIDTH-1]}}, tdata_i[gi]};
      assign shifted = comb_reg[STAGES-1] >>> shamt;
      assign tdata_o[gi] = out_reg;

      // Same-cycle cascade: each integrator adds the freshly updated value of the one before.
      always_comb begin
        integ_next[0] = integ_reg[0] + x_ext;
        for (int k = 1; k < STAGES; k++) begin
          integ_next[k] = integ_reg[k] + integ_next[k-1];
        end
        comb_in[0] = dec_reg;
        for (int k = 1; k < STAGES; k++) begin
          comb_in[k] = comb_reg[k-1];
        end
      end

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          for (int k = 0; k < STAGES; k++) begin
            integ_reg[k]    <= '0;
            comb_reg[k]     <= '0;
            comb_dly_reg[k] <= '0;
          end
          dec_reg <= '0;
          out_reg <= '0;
        end else if (en_i) begin
          if (clr_i) begin
            for (int k = 0; k < STAGES; k++) begin
              integ_reg[k]    <= '0;
              comb_reg[k]     <= '0;
              comb_dly_reg[k] <= '0;
            end
            dec_reg <= '0;
          end else begin
            if (accept) begin
              for (int k = 0; k < STAGES; k++) begin
                integ_reg[k] <= integ_next[k];
              end
              if (dec_last) begin
                dec_reg <= integ_next[STAGES-1];
              end
            end
            for (int k = 0; k < STAGES; k++) begin
              if (vld_reg[k]) begin
                comb_reg[k]     <= comb_in[k] - comb_dly_reg[k];
                comb_dly_reg[k] <= comb_in[k];
              end
            end
            if (vld_reg[STAGES]) begin
              out_reg <= shifted[DATA_WIDTH-1:0];
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: an FIR-form reference (CIC impulse response
// convolved with the accepted-sample history) is checked against the DUT every cycle.
module tb_cic_decimator;

  localparam int STAGES = 3;

  logic                clk_i = 1'b0;
  logic                rstn_i = 1'b0;
  logic                en_i = 1'b0;
  logic                clr_i = 1'b0;
  logic [2:0]          rate_log2_i = '0;
  logic                tvalid_i = 1'b0;
  logic [1:0][15:0]    tdata_i = '0;
  logic                tvalid_o;
  logic [1:0][15:0]    tdata_o;

  cic_decimator #(.IQ_NUM(2), .DATA_WIDTH(16), .STAGES(STAGES), .MAX_LOG2(6)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .clr_i(clr_i),
    .rate_log2_i(rate_log2_i), .tvalid_i(tvalid_i), .tdata_i(tdata_i),
    .tvalid_o(tvalid_o), .tdata_o(tdata_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cnt; longint yi; longint yq; } pend_t;
  int      l_m = 0;
  longint  h [0:255];
  int      hlen = 1;
  longint  hist_i [$];
  longint  hist_q [$];
  pend_t   pend [$];
  logic    exp_v = 1'b0;
  longint  exp_i = 0;
  longint  exp_q = 0;

  // h = coefficients of (1 + z^-1 + ... + z^-(R-1))^N
  task automatic build_h(input int l);
    longint tmp [0:255];
    int r;
    r = 1 << l;
    foreach (h[k]) h[k] = 0;
    h[0] = 1;
    hlen = 1;
    repeat (STAGES) begin
      for (int k = 0; k < hlen + r - 1; k++) begin
        tmp[k] = 0;
        for (int j = 0; j < r; j++)
          if (k - j >= 0 && k - j < hlen) tmp[k] += h[k-j];
      end
      hlen += r - 1;
      for (int k = 0; k < hlen; k++) h[k] = tmp[k];
    end
  endtask

  function automatic longint cic_y(input longint hist [$]);
    longint acc = 0;
    int last = hist.size() - 1;
    for (int n = 0; n < hlen; n++)
      if (last - n >= 0) acc += h[n] * hist[last-n];
    return acc >>> (STAGES * l_m);
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      l_m = 0;
      build_h(0);
      hist_i.delete(); hist_q.delete(); pend.delete();
      exp_v = 1'b0; exp_i = 0; exp_q = 0;
    end else if (en_i) begin
      exp_v = 1'b0;
      if (clr_i) begin
        l_m = (rate_log2_i > 3'd6) ? 6 : int'(rate_log2_i);
        build_h(l_m);
        hist_i.delete(); hist_q.delete(); pend.delete();
      end else begin
        foreach (pend[k]) pend[k].cnt--;
        if (pend.size() > 0 && pend[0].cnt == 0) begin
          exp_v = 1'b1;
          exp_i = pend[0].yi;
          exp_q = pend[0].yq;
          void'(pend.pop_front());
        end
        if (tvalid_i) begin
          hist_i.push_back(longint'($signed(tdata_i[0])));
          hist_q.push_back(longint'($signed(tdata_i[1])));
          if (hist_i.size() % (1 << l_m) == 0)
            pend.push_back('{STAGES + 1, cic_y(hist_i), cic_y(hist_q)});
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  longint out_i [$];
  longint out_q [$];

  always @(negedge clk_i) begin
    check("tvalid", longint'(tvalid_o), longint'(exp_v && en_i && rstn_i));
    check("tdata_i", longint'($signed(tdata_o[0])), exp_i);
    check("tdata_q", longint'($signed(tdata_o[1])), exp_q);
    if (tvalid_o) begin
      out_i.push_back(longint'($signed(tdata_o[0])));
      out_q.push_back(longint'($signed(tdata_o[1])));
      $display("out #%0d  i=%0d q=%0d  t=%0t", out_i.size() - 1,
               $signed(tdata_o[0]), $signed(tdata_o[1]), $time);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic en, input logic clr, input logic tv,
                     input int rate, input int xi, input int xq);
    en_i = en; clr_i = clr; tvalid_i = tv;
    rate_log2_i = 3'(rate);
    tdata_i[0] = 16'(xi);
    tdata_i[1] = 16'(xq);
    @(posedge clk_i); #1;
  endtask

  task automatic clr_to(input int l);
    cyc(1'b1, 1'b1, 1'b1, l, 1234, -1234);  // presented sample must be dropped
  endtask

  task automatic feed(input int n, input int xi, input int xq);
    repeat (n) cyc(1'b1, 1'b0, 1'b1, 0, xi, xq);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  function automatic longint log_i(input int k);
    return (out_i.size() > k) ? out_i[k] : 64'sd999999;
  endfunction

  function automatic longint log_q(input int k);
    return (out_q.size() > k) ? out_q[k] : 64'sd999999;
  endfunction

  task automatic clear_log();
    out_i.delete();
    out_q.delete();
  endtask

  int xs [40];
  int acc_n;
  int cyc_n;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tvalid", longint'(tvalid_o), 0);
    check("rst_tdata", longint'(tdata_o), 0);
    rstn_i = 1'b1;
    idle(2);

    // DC, R=8: first output 120*1000/512 floored, steady state exact
    clear_log();
    clr_to(3);
    feed(56, 1000, -1000);
    idle(6);
    check("dc_count", out_i.size(), 7);
    check("dc_first_i", log_i(0), 234);
    check("dc_first_q", log_q(0), -235);
    for (int k = 3; k < 7; k++) begin
      check("dc_i", log_i(k), 1000);
      check("dc_q", log_q(k), -1000);
    end

    // R=1 pass-through with STAGES+1 latency
    clear_log();
    clr_to(0);
    for (int k = 0; k < 40; k++) begin
      xs[k] = int'($signed(16'($urandom)));
      cyc(1'b1, 1'b0, 1'b1, 0, xs[k], -xs[k] / 2);
    end
    idle(6);
    check("r1_count", out_i.size(), 40);
    for (int k = 0; k < 40; k += 7) check("r1_i", log_i(k), longint'(xs[k]));

    // Full scale at R=64
    clear_log();
    clr_to(6);
    feed(320, -32768, -32768);
    idle(6);
    check("fs_neg_count", out_i.size(), 5);
    check("fs_neg_i", log_i(4), -32768);
    check("fs_neg_q", log_q(3), -32768);
    clear_log();
    clr_to(6);
    feed(320, 32767, 32767);
    idle(6);
    check("fs_pos_i", log_i(4), 32767);
    check("fs_pos_q", log_q(3), 32767);

    // Impulse at R=4: outputs are taps h[3], h[7], h[11]
    clear_log();
    clr_to(2);
    check("model_hlen", hlen, 10);
    check("model_h3", h[3], 10);
    feed(1, 64, -64);
    feed(11, 0, 0);
    idle(6);
    check("imp_count", out_i.size(), 3);
    check("imp0_i", log_i(0), 10);
    check("imp1_i", log_i(1), 6);
    check("imp2_i", log_i(2), 0);
    check("imp1_q", log_q(1), -6);

    // Throttled DC with enable bursts
    clear_log();
    clr_to(3);
    acc_n = 0;
    cyc_n = 0;
    while (acc_n < 56 && cyc_n < 3000) begin
      automatic logic en = ((cyc_n % 37) >= 4);
      automatic logic tv = ($urandom_range(0, 9) < 3);
      if (en && tv) acc_n++;
      cyc(en, 1'b0, tv, 0, 1000, -1000);
      cyc_n++;
    end
    check("thr_budget", longint'(acc_n), 56);
    idle(6);
    check("thr_count", out_i.size(), 7);
    check("thr_first_q", log_q(0), -235);
    check("thr_i", log_i(6), 1000);
    check("thr_q", log_q(5), -1000);

    // clr mid-block: count restarts, next output after 8 new samples
    clear_log();
    clr_to(3);
    feed(5, 300, 300);
    clr_to(3);
    feed(7, 500, 500);
    idle(6);
    check("clr_no_early", out_i.size(), 0);
    feed(1, 500, 500);
    idle(6);
    check("clr_count", out_i.size(), 1);
    check("clr_val", log_i(0), 117);

    // Reset with an output in flight: nothing stale appears
    clear_log();
    feed(8, 500, 500);
    rstn_i = 1'b0;
    idle(2);
    rstn_i = 1'b1;
    idle(8);
    check("rst_no_stale", out_i.size(), 0);
    feed(1, 7, -7);
    idle(6);
    check("rst_r1_count", out_i.size(), 1);
    check("rst_r1_i", log_i(0), 7);
    check("rst_r1_q", log_q(0), -7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
